// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the load/store unit.
// The size codes match the RISC-V funct3 encodings the decoder uses.
package riscv_lsu_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_e;

    // Access size codes (funct3)
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    // Byte-enable base masks, shifted into the addressed lane
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/riscv_lsu_align.sv
// Lane handling for the load/store unit: byte enables, store-data lane
// replication and load-data extraction with sign/zero extension.
// Purely combinational.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rd_i,
    output logic [3:0]  be_o,
    output logic [31:0] wd_o,
    output logic [31:0] rd_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rd_i[{off_i, 3'b000} +: 8];
    // Halfwords ignore off[0]: a half at offset 3 uses bytes 3:2
    assign rd_half = off_i[1] ? rd_i[31:16] : rd_i[15:0];

    // Decode size into lane mask, replicated store data and extended load data
    always_comb begin
        be_o = 4'b0000;
        wd_o = 32'h0;
        rd_o = 32'h0;
        case (size_i)
            LDST_B: begin
                be_o = BE_BYTE << off_i;
                wd_o = {4{wd_i[7:0]}};
                rd_o = {{24{rd_byte[7]}}, rd_byte};
            end
            LDST_BU: begin
                be_o = BE_BYTE << off_i;
                wd_o = {4{wd_i[7:0]}};
                rd_o = {24'h0, rd_byte};
            end
            LDST_H: begin
                be_o = BE_HALF << {off_i[1], 1'b0};
                wd_o = {2{wd_i[15:0]}};
                rd_o = {{16{rd_half[15]}}, rd_half};
            end
            LDST_HU: begin
                be_o = BE_HALF << {off_i[1], 1'b0};
                wd_o = {2{wd_i[15:0]}};
                rd_o = {16'h0, rd_half};
            end
            LDST_W: begin
                be_o = BE_WORD;
                wd_o = wd_i;
                rd_o = rd_i;
            end
            default: begin
                be_o = 4'b0000;
                wd_o = 32'h0;
                rd_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit between the core data port and external data memory.
// Stalls the core while an access is outstanding and force-completes it
// with bus_err_o after TIMEOUT_CYCLES wait cycles (0 disables the watchdog).
// Optional: define RISCV_LSU_MISALIGN_EN to add misalign_o and suppress
// misaligned half/word accesses instead of issuing them.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
`ifdef RISCV_LSU_MISALIGN_EN
    ,
    output logic        misalign_o
`endif
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            bus_err_q, bus_err_d;

    logic            misalign;
    logic            acc_req;
    logic            to_fire;
    logic [3:0]      be;
    logic [31:0]     wd_rep;
    logic [31:0]     rd_ext;

`ifdef RISCV_LSU_MISALIGN_EN
    // Flag half accesses on odd bytes and word accesses off a word boundary
    always_comb begin
        misalign = 1'b0;
        if (core_req_i) begin
            if ((core_size_i == LDST_H || core_size_i == LDST_HU) && core_addr_i[0]) begin
                misalign = 1'b1;
            end else if (core_size_i == LDST_W && core_addr_i[1:0] != 2'b00) begin
                misalign = 1'b1;
            end
        end
    end
    assign misalign_o = misalign;
`else
    assign misalign = 1'b0;
`endif

    // A misaligned request is handed straight to the trap logic, never to memory
    assign acc_req = core_req_i & ~misalign;

    assign to_fire = (TIMEOUT_CYCLES != 0) && (state_q == WAIT) && acc_req && !mem_ready_i
                     && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    riscv_lsu_align u_align (
        .size_i (core_size_i),
        .off_i  (core_addr_i[1:0]),
        .wd_i   (core_wd_i),
        .rd_i   (mem_rd_i),
        .be_o   (be),
        .wd_o   (wd_rep),
        .rd_o   (rd_ext)
    );

    assign mem_req_o  = acc_req;
    assign mem_we_o   = acc_req & core_we_i;
    assign mem_be_o   = acc_req ? be : 4'b0000;
    assign mem_addr_o = acc_req ? {core_addr_i[31:2], 2'b00} : 32'h0;
    assign mem_wd_o   = acc_req ? wd_rep : 32'h0;
    assign core_rd_o  = (acc_req && !to_fire) ? rd_ext : 32'h0;
    assign bus_err_o  = bus_err_q;

    // Next-state, watchdog count and stall decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_err_d    = 1'b0;
        core_stall_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (acc_req) begin
                    state_d      = WAIT;
                    core_stall_o = 1'b1;
                end
            end
            WAIT: begin
                if (!acc_req || mem_ready_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (to_fire) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                end else begin
                    core_stall_o = 1'b1;
                    if (TIMEOUT_CYCLES != 0) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
        endcase
    end

    // FSM state, watchdog counter and registered error pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu (watchdog set to 4 cycles).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        bus_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;
`ifdef RISCV_LSU_MISALIGN_EN
    logic        misalign_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    riscv_lsu #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .bus_err_o    (bus_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
`ifdef RISCV_LSU_MISALIGN_EN
        ,
        .misalign_o   (misalign_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input logic ready);
        core_req_i  = req;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_rd_i    = rd;
        mem_ready_i = ready;
        #1;
    endtask

    // Advance to the next falling edge
    task automatic nxt();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        // Reset
        rst_ni = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rst_stall", 32'(core_stall_o), 32'd0);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_err", 32'(bus_err_o), 32'd0);
        chk("rst_rd", core_rd_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        nxt();

        // SW 0x104
        drive(1'b1, 1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0, 1'b0);
        chk("sw_be", 32'(mem_be_o), 32'hF);
        chk("sw_addr", mem_addr_o, 32'h104);
        chk("sw_wd", mem_wd_o, 32'hDEADBEEF);
        chk("sw_we", 32'(mem_we_o), 32'd1);
        chk("sw_req", 32'(mem_req_o), 32'd1);
        chk("sw_stall0", 32'(core_stall_o), 32'd1);
        nxt();
        drive(1'b1, 1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0, 1'b1);
        chk("sw_stall1", 32'(core_stall_o), 32'd0);
        nxt();
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("idle_req", 32'(mem_req_o), 32'd0);
        chk("idle_stall", 32'(core_stall_o), 32'd0);
        chk("idle_be", 32'(mem_be_o), 32'd0);

        // SB 0x203
        drive(1'b1, 1'b1, 3'd0, 32'h203, 32'h000000A5, 32'h0, 1'b0);
        chk("sb_be", 32'(mem_be_o), 32'h8);
        chk("sb_wd", mem_wd_o, 32'hA5A5A5A5);
        chk("sb_addr", mem_addr_o, 32'h200);
        chk("sb_stall", 32'(core_stall_o), 32'd1);
        nxt();
        drive(1'b1, 1'b1, 3'd0, 32'h203, 32'h000000A5, 32'h0, 1'b1);
        chk("sb_done", 32'(core_stall_o), 32'd0);
        nxt();

        // LB 0x002, three stall cycles
        drive(1'b1, 1'b0, 3'd0, 32'h002, 32'h0, 32'h0080FF00, 1'b0);
        chk("lb_be", 32'(mem_be_o), 32'h4);
        chk("lb_we", 32'(mem_we_o), 32'd0);
        chk("lb_st0", 32'(core_stall_o), 32'd1);
        nxt();
        chk("lb_st1", 32'(core_stall_o), 32'd1);
        nxt();
        chk("lb_st2", 32'(core_stall_o), 32'd1);
        nxt();
        drive(1'b1, 1'b0, 3'd0, 32'h002, 32'h0, 32'h0080FF00, 1'b1);
        chk("lb_st3", 32'(core_stall_o), 32'd0);
        chk("lb_rd", core_rd_o, 32'hFFFFFF80);
        nxt();
        // LBU, same word
        drive(1'b1, 1'b0, 3'd4, 32'h002, 32'h0, 32'h0080FF00, 1'b0);
        chk("lbu_stall", 32'(core_stall_o), 32'd1);
        nxt();
        drive(1'b1, 1'b0, 3'd4, 32'h002, 32'h0, 32'h0080FF00, 1'b1);
        chk("lbu_rd", core_rd_o, 32'h00000080);
        nxt();

        // LH / LHU at 0x002, LW at 0x000
        drive(1'b1, 1'b0, 3'd1, 32'h002, 32'h0, 32'h80011234, 1'b0);
        chk("lh_be", 32'(mem_be_o), 32'hC);
        nxt();
        drive(1'b1, 1'b0, 3'd1, 32'h002, 32'h0, 32'h80011234, 1'b1);
        chk("lh_rd", core_rd_o, 32'hFFFF8001);
        nxt();
        drive(1'b1, 1'b0, 3'd5, 32'h002, 32'h0, 32'h80011234, 1'b0);
        nxt();
        drive(1'b1, 1'b0, 3'd5, 32'h002, 32'h0, 32'h80011234, 1'b1);
        chk("lhu_rd", core_rd_o, 32'h00008001);
        nxt();
        drive(1'b1, 1'b0, 3'd2, 32'h000, 32'h0, 32'h80011234, 1'b0);
        nxt();
        drive(1'b1, 1'b0, 3'd2, 32'h000, 32'h0, 32'h80011234, 1'b1);
        chk("lw_rd", core_rd_o, 32'h80011234);
        nxt();

`ifndef RISCV_LSU_MISALIGN_EN
        // Misaligned half at offset 3 uses bytes 3:2
        drive(1'b1, 1'b0, 3'd1, 32'h003, 32'h0, 32'h7F00AA55, 1'b0);
        chk("lh3_be", 32'(mem_be_o), 32'hC);
        nxt();
        drive(1'b1, 1'b0, 3'd1, 32'h003, 32'h0, 32'h7F00AA55, 1'b1);
        chk("lh3_rd", core_rd_o, 32'h00007F00);
        nxt();
`endif

        // Undefined size code 3
        drive(1'b1, 1'b0, 3'd3, 32'h000, 32'h0, 32'hFFFFFFFF, 1'b0);
        chk("sz3_be", 32'(mem_be_o), 32'h0);
        nxt();
        drive(1'b1, 1'b0, 3'd3, 32'h000, 32'h0, 32'hFFFFFFFF, 1'b1);
        chk("sz3_rd", core_rd_o, 32'h0);
        nxt();

        // Watchdog: ready never arrives, released on the 4th WAIT cycle
        drive(1'b1, 1'b0, 3'd2, 32'h010, 32'h0, 32'h12345678, 1'b0);
        chk("to_idle_st", 32'(core_stall_o), 32'd1);
        nxt();
        chk("to_w1_st", 32'(core_stall_o), 32'd1);
        nxt();
        chk("to_w2_st", 32'(core_stall_o), 32'd1);
        nxt();
        chk("to_w3_st", 32'(core_stall_o), 32'd1);
        chk("to_w3_err", 32'(bus_err_o), 32'd0);
        nxt();
        chk("to_w4_st", 32'(core_stall_o), 32'd0);
        chk("to_w4_rd", core_rd_o, 32'h0);
        chk("to_w4_err", 32'(bus_err_o), 32'd0);
        nxt();
        // Next request presented while the error pulse is visible
        drive(1'b1, 1'b1, 3'd2, 32'h020, 32'hCAFEF00D, 32'h0, 1'b0);
        chk("to_err_pulse", 32'(bus_err_o), 32'd1);
        chk("to_next_st", 32'(core_stall_o), 32'd1);
        chk("to_next_req", 32'(mem_req_o), 32'd1);
        nxt();
        drive(1'b1, 1'b1, 3'd2, 32'h020, 32'hCAFEF00D, 32'h0, 1'b1);
        chk("to_err_end", 32'(bus_err_o), 32'd0);
        chk("to_next_done", 32'(core_stall_o), 32'd0);
        nxt();

        // Request dropped while waiting: back to IDLE without error
        drive(1'b1, 1'b0, 3'd2, 32'h030, 32'h0, 32'h0, 1'b0);
        nxt();
        drive(1'b0, 1'b0, 3'd2, 32'h030, 32'h0, 32'h0, 1'b0);
        chk("drop_st", 32'(core_stall_o), 32'd0);
        nxt();
        chk("drop_err", 32'(bus_err_o), 32'd0);
        // Ready in IDLE is ignored: stall still asserted for the first cycle
        drive(1'b1, 1'b0, 3'd2, 32'h030, 32'h0, 32'h0, 1'b1);
        chk("idle_rdy_st", 32'(core_stall_o), 32'd1);
        nxt();
        chk("idle_rdy_done", 32'(core_stall_o), 32'd0);
        nxt();

        // Reset asserted during WAIT
        drive(1'b1, 1'b0, 3'd2, 32'h040, 32'h0, 32'h0, 1'b0);
        nxt();
        chk("rstw_wait_st", 32'(core_stall_o), 32'd1);
        rst_ni = 1'b0;
        drive(1'b0, 1'b0, 3'd2, 32'h040, 32'h0, 32'h0, 1'b0);
        chk("rstw_st", 32'(core_stall_o), 32'd0);
        chk("rstw_req", 32'(mem_req_o), 32'd0);
        nxt();
        rst_ni = 1'b1;
        nxt();
        drive(1'b1, 1'b0, 3'd2, 32'h040, 32'h0, 32'h0, 1'b1);
        chk("rstw_idle", 32'(core_stall_o), 32'd1);
        nxt();
        chk("rstw_done", 32'(core_stall_o), 32'd0);
        nxt();

`ifdef RISCV_LSU_MISALIGN_EN
        // Misaligned LW is trapped, not issued
        drive(1'b1, 1'b0, 3'd2, 32'h006, 32'h0, 32'h0, 1'b0);
        chk("mis_flag", 32'(misalign_o), 32'd1);
        chk("mis_req", 32'(mem_req_o), 32'd0);
        chk("mis_st", 32'(core_stall_o), 32'd0);
        nxt();
        drive(1'b1, 1'b0, 3'd1, 32'h004, 32'h0, 32'h0, 1'b0);
        chk("mis_ok_flag", 32'(misalign_o), 32'd0);
        chk("mis_ok_st", 32'(core_stall_o), 32'd1);
        nxt();
        drive(1'b1, 1'b0, 3'd1, 32'h004, 32'h0, 32'h0, 1'b1);
        nxt();
`endif

        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit between the single-cycle core's data-memory port and the external data memory.
- Converts core requests (address, size, write data) into byte-enabled, word-aligned memory transactions.
- Stalls the core until memory returns ready, then sign/zero-extends load data back to the core's write-back mux.
- Includes a bus timeout watchdog so a dead slave cannot hang the core.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for mem_ready_i before the access is force-completed with error; 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  1  core requests a data access this cycle
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  RISC-V funct3 size code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- core_addr_i  in  32  byte address from the ALU
- core_wd_i  in  32  store data (rs2)
- core_rd_o  out  32  extended load data to write-back
- core_stall_o  out  1  freeze PC and register-file write
- bus_err_o  out  1  one-cycle pulse: access ended by timeout
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word-aligned address, bits [1:0] = 0
- mem_wd_o  out  32  lane-replicated store data
- mem_rd_i  in  32  memory read word
- mem_ready_i  in  1  memory completes the access this cycle

Behaviour:
- Reset, asynchronous on rst_ni low: state = IDLE, timeout counter = 0, bus_err_o = 0.
- All other outputs are combinational from state and inputs. With core_req_i = 0 they are all 0.
- FSM states: IDLE, WAIT.
  - IDLE with core_req_i = 1: go to WAIT, core_stall_o = 1, mem_req_o = 1.
  - WAIT with mem_ready_i = 1: core_stall_o = 0 in that same cycle; next state IDLE.
  - WAIT with mem_ready_i = 0: stay in WAIT, stall held.
  - Minimum access latency is 2 cycles, i.e. 1 stall cycle. mem_ready_i in IDLE is ignored.
- mem_req_o = core_req_i in both states. mem_we_o = core_we_i & core_req_i. mem_addr_o = {core_addr_i[31:2], 2'b00}.
- Byte enables, with off = core_addr_i[1:0]:
  - byte: 4'b0001 << off
  - half: 4'b0011 << {off[1], 1'b0}
  - word: 4'b1111
  - loads drive mem_be_o the same way.
- Store data:
  - byte: {4{wd[7:0]}}
  - half: {2{wd[15:0]}}
  - word: wd
- Load extraction:
  - Select byte off, or half off[1], from mem_rd_i.
  - Sizes 0/1 sign-extend; 4/5 zero-extend; 2 passes mem_rd_i through.
  - Undefined size codes (3, 6, 7) yield 0 and mem_be_o = 0.
- Misalignment without the optional feature: the address low bits not covered by the size are ignored. A half at off = 3 uses bytes 3:2; a word always uses the full word.
- Timeout (TIMEOUT_CYCLES > 0):
  - Counter increments each WAIT cycle without ready and clears on leaving WAIT.
  - When the counter reaches TIMEOUT_CYCLES-1 without ready, the stall is released that cycle, core_rd_o = 0, bus_err_o pulses next cycle, and state goes to IDLE.
- Back-to-back requests: after a WAIT→IDLE completion the core presents the next instruction; a new request restarts the FSM, so there is no combinational path from mem_ready_i to mem_req_o.
- core_req_i dropping while in WAIT (only possible via reset/flush): return to IDLE, no stall, no error.
- Reset asserted mid-access: immediate return to IDLE; the memory must tolerate the request vanishing.

Optional Feature:
- Macro: RISCV_LSU_MISALIGN_EN.
- When defined:
  - Adds output misalign_o (1 bit). It is high combinationally when core_req_i is high and the access is misaligned: half with addr[0] = 1, or word with addr[1:0] != 0.
  - A misaligned request suppresses mem_req_o and core_stall_o (zero-latency trap handoff); the FSM stays IDLE.
- When undefined: no port; behaviour as above.

Decomposition:
- Package riscv_lsu_pkg holds:
  - enum lsu_state_e {IDLE, WAIT}
  - size localparams LDST_B = 3'd0, LDST_H = 3'd1, LDST_W = 3'd2, LDST_BU = 3'd4, LDST_HU = 3'd5, shared with the decoder
  - function-free constants for the byte-enable base masks
- One sub-module, riscv_lsu_align: purely combinational byte-enable, store replicate and load extract.
- The FSM and watchdog stay in the top module.

Test Plan:
- SW addr 0x104, wd 0xDEADBEEF, ready after 1 cycle -> be 1111, addr 0x104, wd 0xDEADBEEF, stall high exactly 1 cycle.
- SB addr 0x203, wd 0x000000A5 -> be 1000, mem_wd 0xA5A5A5A5, addr 0x200.
- LB addr 0x002, mem_rd 0x0080FF00, ready after 3 wait cycles -> stall for 3 cycles then released, core_rd 0xFFFFFF80; LBU same -> 0x00000080.
- LH addr 0x002, mem_rd 0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001; LW -> 0x80011234.
- TIMEOUT_CYCLES = 4, ready never asserted -> stall released on the 4th WAIT cycle, core_rd 0, bus_err_o single-cycle pulse, next request accepted normally.
- rst_ni pulled low during WAIT -> stall and mem_req low immediately (with core_req_i low); with RISCV_LSU_MISALIGN_EN, LW addr 0x006 -> misalign_o = 1, mem_req_o = 0, no stall.
